// File: rtl/dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dmem_arbiter                                                  |
// | Brief    : Round-robin, lockable two-port arbiter for the word data RAM  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic              req0_lock,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic              req1_lock,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);
    localparam int                 c_CNT_W    = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_last_grant;
    logic               w_next_last;
    logic [c_CNT_W-1:0] r_lock_cnt;
    logic [c_CNT_W-1:0] w_next_cnt;

    logic [1:0] w_valid;
    logic [1:0] w_write;
    logic [1:0] w_lock;
    logic [1:0] w_aligned;
    logic [1:0] w_gnt;
    logic       w_xfer;
    logic       w_xfer_lock;

    assign w_valid   = {req1_valid, req0_valid};
    assign w_write   = {req1_write, req0_write};
    assign w_lock    = {req1_lock, req0_lock};
    assign w_aligned = {(req1_addr[1:0] == 2'b00), (req0_addr[1:0] == 2'b00)};

    assign w_xfer      = |w_gnt;
    assign w_xfer_lock = |(w_gnt & w_lock);

    // A lock owner shuts the other port out; otherwise ties go to the port not served last.
    always_comb begin
        w_gnt = 2'b00;
        if (!rst) begin
            case (r_state)
                ST_LOCK0: w_gnt[0] = w_valid[0];
                ST_LOCK1: w_gnt[1] = w_valid[1];
                default: begin
                    if (&w_valid) begin
                        w_gnt = r_last_grant ? 2'b01 : 2'b10;
                    end else begin
                        w_gnt = w_valid;
                    end
                end
            endcase
        end
    end

    assign req0_ready     = w_gnt[0];
    assign req1_ready     = w_gnt[1];
    assign mem_write      = |(w_gnt & w_write & w_aligned);
    assign mem_address    = w_gnt[1] ? req1_addr : req0_addr;
    assign mem_write_data = w_gnt[1] ? req1_wdata : req0_wdata;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = '0;
        w_next_last  = r_last_grant;
        if (w_xfer) begin
            w_next_last = w_gnt[1];
        end
        case (r_state)
            ST_LOCK0, ST_LOCK1: begin
                if (w_xfer) begin
                    if (!w_xfer_lock) begin
                        w_next_state = ST_ARB;
                    end
                end else if (r_lock_cnt == c_CNT_LAST) begin
                    // Counter would reach the limit this edge: release now.
                    w_next_state = ST_ARB;
                end else begin
                    w_next_cnt = r_lock_cnt + c_CNT_W'(1);
                end
            end
            default: begin
                w_next_state = ST_ARB;
                if (w_xfer && w_xfer_lock) begin
                    w_next_state = w_gnt[1] ? ST_LOCK1 : ST_LOCK0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_ARB;
            r_last_grant <= 1'b1;
            r_lock_cnt   <= '0;
        end else begin
            r_state      <= w_next_state;
            r_last_grant <= w_next_last;
            r_lock_cnt   <= w_next_cnt;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_rsp
        logic              r_valid;
        logic              r_err;
        logic [DATA_W-1:0] r_rdata;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_err   <= 1'b0;
                r_rdata <= '0;
            end else begin
                r_valid <= w_gnt[p] & (~w_write[p] | ~w_aligned[p]);
                r_err   <= w_gnt[p] & ~w_aligned[p];
                r_rdata <= (w_gnt[p] & ~w_write[p] & w_aligned[p]) ? mem_read_data : '0;
            end
        end
    end

    // Gating with rst drops a response that was pending when reset arrived.
    assign rsp0_valid = g_rsp[0].r_valid & ~rst;
    assign rsp0_err   = g_rsp[0].r_err & ~rst;
    assign rsp0_rdata = rst ? '0 : g_rsp[0].r_rdata;
    assign rsp1_valid = g_rsp[1].r_valid & ~rst;
    assign rsp1_err   = g_rsp[1].r_err & ~rst;
    assign rsp1_rdata = rst ? '0 : g_rsp[1].r_rdata;

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter sharing the single-port word data memory (1024 x 32, synchronous write, asynchronous read, word index = address[11:2]).
- Port 0 is the CPU load/store unit; port 1 is the debug/DMA loader.
- Round-robin grant, valid/ready request handshake, registered read responses, optional lock for atomic read-modify-write.
- Sits between both requesters and the memory's mem_write/address/write_data/read_data pins.

Parameters:
- ADDR_W, 32, request/memory address width.
- DATA_W, 32, data width.
- LOCK_TIMEOUT, 16, idle cycles after which a held lock is force-released (>=1).

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  synchronous active-high reset.
- reqN_valid  in  1  request present (N = 0, 1, one set per requester).
- reqN_ready  out  1  request accepted this cycle; transfer = valid & ready.
- reqN_write  in  1  1 = store, 0 = load.
- reqN_lock  in  1  keep grant for this requester after this transfer.
- reqN_addr  in  ADDR_W  byte address.
- reqN_wdata  in  DATA_W  store data.
- rspN_valid  out  1  one-cycle pulse: load data or error ready.
- rspN_rdata  out  DATA_W  load data, valid with rspN_valid.
- rspN_err  out  1  misaligned access flag, valid with rspN_valid.
- mem_write  out  1  to memory write enable.
- mem_address  out  ADDR_W  to memory address.
- mem_write_data  out  DATA_W  to memory write data.
- mem_read_data  in  DATA_W  from memory asynchronous read data.

Behaviour:
- Reset: state=ARB, last_grant=1 (port 0 wins first tie), lock_cnt=0. All rspN_valid/rspN_rdata/rspN_err = 0. While rst=1: reqN_ready=0, mem_write=0.
- Grant is combinational each cycle; at most one reqN_ready high.
  - ARB: one valid -> grant it. Both valid -> grant the port != last_grant.
  - LOCKED(o): only port o may be granted; the other port's ready stays 0 even if it is valid.
- Memory drive:
  - mem_address/mem_write_data mux from the granted port; port 0 when none granted.
  - mem_write = granted & write & aligned.
  - Memory commits the store at the same posedge as the handshake.
- Alignment: aligned = addr[1:0]==0.
  - Misaligned transfer is still accepted (ready=1), but mem_write=0.
  - Next cycle: rspN_valid=1, rspN_err=1, rspN_rdata=0, for both loads and stores.
- Load latency 1:
  - Accepted aligned load in cycle T -> rspN_valid=1, rspN_rdata = mem_read_data sampled at end of T, err=0, in cycle T+1.
  - Aligned stores produce no response.
  - A new request may be accepted every cycle; responses are in order, one per load.
- last_grant updates to the accepted port on every transfer; unchanged on idle cycles.
- Lock FSM:
  - ARB -> LOCKED(N) on a transfer from N with reqN_lock=1.
  - LOCKED(o) -> stays on a transfer from o with lock=1.
  - LOCKED(o) -> ARB on a transfer from o with lock=0, or when lock_cnt reaches LOCK_TIMEOUT.
  - lock_cnt clears on any transfer or state entry, and increments on LOCKED cycles with no transfer.
  - Timeout release takes effect the following cycle; the other port may then be granted.
- Simultaneous events: a lock-release transfer and the other port's pending request -> the other port is granted in the next cycle (last_grant rule).
- Reset mid-operation: a pending response is dropped (rspN_valid=0 during and after the reset cycle), lock is released, and no store is issued in the reset cycle.

Test Plan:
- Single store/load, port 0: store 0xDEADBEEF @0x10, then load @0x10 -> mem_write=1 one cycle; rsp0_valid one cycle after the load with rdata=0xDEADBEEF, err=0.
- Contention: both valid continuously with loads @0x0 / @0x4 after reset -> grants 0,1,0,1...; each rspN_valid follows its own grant by exactly 1 cycle.
- Misaligned: req1 load @0x6 -> ready=1, mem_write=0, next cycle rsp1_valid=1, err=1, rdata=0. Misaligned store @0x13 leaves mem[4] unchanged.
- Lock: port 1 load @0x20 with lock=1, port 0 valid throughout -> port 0 not granted until port 1 stores @0x20 with lock=0; then port 0 granted the next cycle.
- Lock timeout, LOCK_TIMEOUT=4: port 0 locks then idles, port 1 valid -> port 1 granted on the 5th cycle after the lock transfer.
- Reset mid-load: load accepted in cycle T, rst=1 in T+1 -> rsp0_valid=0 in T+1; first grant after reset goes to port 0 on a tie.
